uart_tx_engine: RTL and testbench
=================================

UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning FIFO read-data width (8 or 9).
REQ-002 SHALL have parameter OVERSAMPLE, default 16, meaning tick pulses per serial bit period (2..64).
REQ-003 SHALL have port clk, input, 1 bit, system clock; all logic on rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit, reset, asynchronous, active-low.
REQ-005 SHALL have port tick, input, 1 bit, oversample strobe from the baud generator, one clk wide.
REQ-006 SHALL have port tx_en, input, 1 bit, permits starting new frames.
REQ-007 SHALL have port cfg_len, input, 2 bits, data bits: 00=5, 01=6, 10=7, 11=8.
REQ-008 SHALL have port cfg_par, input, 2 bits, parity: 00=none, 01=even, 10=odd, 11=none.
REQ-009 SHALL have port cfg_stop2, input, 1 bit, 0=one stop bit, 1=two stop bits.
REQ-010 SHALL have port fifo_empty, input, 1 bit, TX FIFO empty flag.
REQ-011 SHALL have port fifo_rdata, input, DATA_W bits, first-word-fall-through FIFO head.
REQ-012 SHALL have port fifo_rd, output, 1 bit, one-cycle FIFO pop.
REQ-013 SHALL have port txd, output, 1 bit, registered serial line, idle high.
REQ-014 SHALL have port busy, output, 1 bit, high in any state other than IDLE.
REQ-015 SHALL have port frame_done, output, 1 bit, one-cycle pulse at end of last stop bit.

Function
REQ-016 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-017 IDLE: when tx_en=1 and fifo_empty=0, SHALL assert fifo_rd for exactly one cycle, latch fifo_rdata[7:0], cfg_len, cfg_par and cfg_stop2, clear the tick counter and bit counter, and enter START next cycle.
REQ-018 txd SHALL be 0 from the first cycle in START; each bit period SHALL last exactly OVERSAMPLE tick pulses, counted from the frame start.
REQ-019 DATA SHALL shift out cfg_len+5 bits, LSB first; bits above the configured length SHALL be ignored.
REQ-020 PARITY SHALL be entered only if the latched cfg_par is 01 or 10; even = XOR of the transmitted data bits, odd = its inverse.
REQ-021 STOP SHALL drive txd=1 for 1 or 2 bit periods per the latched cfg_stop2.
REQ-022 On the final tick of STOP, the FSM SHALL pulse frame_done and return to IDLE, so back-to-back frames have a gap of at most 1 clk with txd=1.
REQ-023 Configuration input changes during a frame SHALL NOT affect that frame.
REQ-024 Deasserting tx_en mid-frame SHALL let the current frame complete and SHALL block the next start.
REQ-025 With no tick pulses, state, counters and txd SHALL hold unchanged.
REQ-026 fifo_rd SHALL never assert while fifo_empty=1 or busy=1.

Reset
REQ-027 On reset_n=0, state SHALL be IDLE, with txd=1, busy=0, fifo_rd=0, frame_done=0, and all counters and the shift register at 0, asynchronously, including mid-frame.
REQ-028 After reset release, the first fifo_rd SHALL occur no earlier than the first clk edge with tx_en=1 and fifo_empty=0.

Structure
REQ-029 The FSM state enum, the cfg_par encoding constants and the OVERSAMPLE default SHALL live in shared package uart_pkg.
REQ-030 The design SHALL be a single module with no sub-module; tick/bit counters and parity are inline.

Verification
REQ-031 The bench SHALL cover: tick every clk, 8N1, data 0xA5 -> txd 0,1,0,1,0,0,1,0,1,1, each held 16 ticks; 160 ticks total; one frame_done.
REQ-032 The bench SHALL cover: 7E2, data 0x41 -> txd 0,1,0,0,0,0,0,1,0(parity),1,1; 176 ticks.
REQ-033 The bench SHALL cover: 5O1, data 0xFF -> txd 0,1,1,1,1,1,0(parity),1; bits 7:5 not sent.
REQ-034 The bench SHALL cover: FIFO holding 0x11, 0x22, tx_en=1 -> two fifo_rd pulses, two frames, inter-frame gap of at most 1 clk with txd=1.
REQ-035 The bench SHALL cover: reset_n pulsed low during DATA bit 3 -> txd=1 and busy=0 immediately; no fifo_rd while the FIFO is empty after release.
REQ-036 The bench SHALL cover: cfg_len changed 11->00 mid-frame, plus tick gated off for 50 clks -> frame still 8 data bits, line frozen during the gap.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, parity encodings,
// default oversampling ratio and the data-length mask helper.
package uart_pkg;

    localparam int OVERSAMPLE_DEF = 16;

    // cfg_par encodings; 00 and 11 both mean "no parity bit".
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    // Mask of the data bits actually sent for a cfg_len code
    // (00 -> 5 bits ... 11 -> 8 bits).
    function automatic logic [7:0] len_mask(input logic [1:0] len);
        return 8'hFF >> (2'd3 - len);
    endfunction

endpackage

// File: rtl/uart_tx_engine.sv
// UART transmit engine: pops bytes from a FWFT FIFO and serialises them as
// start / 5..8 data (LSB first) / optional parity / 1..2 stop bits.
// Ports: clk, reset_n (async, active-low), tick (oversample strobe),
//   tx_en, cfg_len, cfg_par, cfg_stop2, fifo_empty, fifo_rdata -> inputs;
//   fifo_rd (pop), txd (registered line), busy, frame_done -> outputs.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              tick,
    input  logic              tx_en,
    input  logic [1:0]        cfg_len,
    input  logic [1:0]        cfg_par,
    input  logic              cfg_stop2,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_rdata,
    output logic              fifo_rd,
    output logic              txd,
    output logic              busy,
    output logic              frame_done
);

    localparam int TW = 6;
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

    tx_state_t     state;
    tx_state_t     state_nx;
    logic [TW-1:0] tick_cnt;
    logic [3:0]    bit_cnt;
    logic [7:0]    shreg;
    logic [1:0]    len_q;
    logic [1:0]    par_q;
    logic          stop2_q;
    logic          par_bit_q;

    logic start;
    logic bit_end;
    logic data_last;
    logic stop_last;
    logic par_en;
    logic par_calc;

    assign start     = tx_en && !fifo_empty;
    assign bit_end   = tick && (tick_cnt == TICK_LAST);
    assign data_last = (bit_cnt == ({2'b00, len_q} + 4'd4));
    assign stop_last = (bit_cnt == {3'b000, stop2_q});
    assign par_en    = (par_q == PAR_EVEN) || (par_q == PAR_ODD);

    // Parity is fixed at frame start from the bits that will be sent.
    assign par_calc = (^(fifo_rdata[7:0] & len_mask(cfg_len)))
                    ^ (cfg_par == PAR_ODD);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (start) state_nx = ST_START;
            end
            ST_START: begin
                if (bit_end) state_nx = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end && data_last)
                    state_nx = par_en ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                if (bit_end) state_nx = ST_STOP;
            end
            ST_STOP: begin
                if (bit_end && stop_last) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // fifo_rd is gated by reset_n so a held reset never pops the FIFO.
    always_comb begin
        busy       = (state != ST_IDLE);
        fifo_rd    = reset_n && (state == ST_IDLE) && start;
        frame_done = (state == ST_STOP) && bit_end && stop_last;
    end

    // txd is loaded with the value of the state being entered, so the
    // line changes on the same edge as the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            len_q     <= '0;
            par_q     <= '0;
            stop2_q   <= 1'b0;
            par_bit_q <= 1'b0;
            txd       <= 1'b1;
        end else if (state == ST_IDLE) begin
            if (start) begin
                shreg     <= fifo_rdata[7:0];
                len_q     <= cfg_len;
                par_q     <= cfg_par;
                stop2_q   <= cfg_stop2;
                par_bit_q <= par_calc;
                tick_cnt  <= '0;
                bit_cnt   <= '0;
                txd       <= 1'b0;
            end
        end else if (tick) begin
            tick_cnt <= bit_end ? '0 : tick_cnt + TW'(1);
            if (bit_end) begin
                unique case (state)
                    ST_START: begin
                        txd <= shreg[0];
                    end
                    ST_DATA: begin
                        if (data_last) begin
                            bit_cnt <= '0;
                            txd     <= par_en ? par_bit_q : 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                            shreg   <= shreg >> 1;
                            txd     <= shreg[1];
                        end
                    end
                    ST_PARITY: begin
                        bit_cnt <= '0;
                        txd     <= 1'b1;
                    end
                    ST_STOP: begin
                        bit_cnt <= stop_last ? 4'd0 : bit_cnt + 4'd1;
                        txd     <= 1'b1;
                    end
                    default: begin
                        txd <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine: frame-level reference model
// plus directed frames with hand-written line sequences.
module tb_uart_tx_engine;

    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       tick = 1'b0;
    logic       tx_en = 1'b0;
    logic [1:0] cfg_len = 2'b11;
    logic [1:0] cfg_par = 2'b00;
    logic       cfg_stop2 = 1'b0;
    logic       fifo_empty;
    logic [7:0] fifo_rdata;
    logic       fifo_rd;
    logic       txd;
    logic       busy;
    logic       frame_done;

    uart_tx_engine #(.DATA_W(8), .OVERSAMPLE(OS)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tick       (tick),
        .tx_en      (tx_en),
        .cfg_len    (cfg_len),
        .cfg_par    (cfg_par),
        .cfg_stop2  (cfg_stop2),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_rd    (fifo_rd),
        .txd        (txd),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    bit tick_on = 1'b1;
    int tick_div = 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // FWFT FIFO: storage/write pointer owned by the stimulus,
    // read pointer advanced by the DUT pop.
    logic [7:0] mem [0:31];
    logic [4:0] wp = 5'd0;
    logic [4:0] rp = 5'd0;
    assign fifo_empty = (rp == wp);
    assign fifo_rdata = mem[rp];

    always @(posedge clk) if (fifo_rd) rp <= rp + 5'd1;

    task automatic push(input logic [7:0] b);
        mem[wp] = b;
        wp = wp + 5'd1;
    endtask

    // Tick strobe, updated after the driver so a driver change of
    // tick_on takes effect in the same cycle.
    initial forever begin
        @(posedge clk);
        #2;
        cyc++;
        tick = tick_on && (cyc % tick_div == 0);
    end

    // Reference model: a frame is a list of line bits; the frame ends
    // after (bits * OS) ticks counted from the first START cycle.
    bit m_active = 1'b0;
    int m_ticks = 0;
    bit m_bits[$];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_active = 1'b0;
            m_ticks = 0;
        end else if (!m_active) begin
            if (tx_en && !fifo_empty) begin
                bit p;
                p = 1'b0;
                m_bits.delete();
                m_bits.push_back(1'b0);
                for (int i = 0; i < int'(cfg_len) + 5; i++) begin
                    m_bits.push_back(fifo_rdata[i]);
                    p ^= fifo_rdata[i];
                end
                if (cfg_par == 2'b01) m_bits.push_back(p);
                if (cfg_par == 2'b10) m_bits.push_back(~p);
                m_bits.push_back(1'b1);
                if (cfg_stop2) m_bits.push_back(1'b1);
                m_active = 1'b1;
                m_ticks = 0;
            end
        end else if (tick) begin
            m_ticks++;
            if (m_ticks == m_bits.size() * OS) m_active = 1'b0;
        end
    end

    int done_cnt = 0;
    int rd_cnt = 0;
    int last_done_cyc = 0;
    int last_gap = 99;
    bit prev_busy = 1'b0;
    bit cap[$];

    always @(negedge clk) begin
        logic e_txd;
        logic e_rd;
        logic e_done;
        e_txd = m_active ? m_bits[m_ticks / OS] : 1'b1;
        e_rd = reset_n && !m_active && tx_en && !fifo_empty;
        e_done = m_active && tick
              && (m_ticks == m_bits.size() * OS - 1);
        chk("txd", txd, e_txd);
        chk("busy", busy, m_active);
        chk("fifo_rd", fifo_rd, e_rd);
        chk("frame_done", frame_done, e_done);
        if (busy && tick) cap.push_back(txd);
        if (frame_done) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
        if (fifo_rd) rd_cnt++;
        if (busy && !prev_busy) last_gap = cyc - last_done_cyc - 1;
        prev_busy = busy;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            step(1);
            n++;
        end
        if (done_cnt < target) chk("timeout_done", done_cnt, target);
        step(1);
    endtask

    task automatic wait_cap(input int target, input int budget);
        int n;
        n = 0;
        while (cap.size() < target && n < budget) begin
            step(1);
            n++;
        end
        if (cap.size() < target) chk("timeout_cap", cap.size(), target);
    endtask

    // Sample each captured bit in the middle of its OS-tick period.
    task automatic check_frame(input string name, input string s,
                               input int off);
        for (int i = 0; i < s.len(); i++) begin
            int k;
            k = off + i * OS + OS / 2;
            chk(name, (k < cap.size()) ? cap[k] : 1'bx,
                (s[i] == 8'h31));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end expected finish");
        $fatal(1);
    end

    initial begin
        int d0;
        int r0;

        // Reset state, with data waiting and tx_en high.
        cfg_len = 2'b11; cfg_par = 2'b00; cfg_stop2 = 1'b0;
        push(8'hA5);
        tx_en = 1'b1;
        step(3);
        chk("rst_txd", txd, 1);
        chk("rst_busy", busy, 0);
        chk("rst_fifo_rd", fifo_rd, 0);
        chk("rst_frame_done", frame_done, 0);

        // 8N1 0xA5, tick every clk.
        cap.delete();
        d0 = done_cnt;
        reset_n = 1'b1;
        wait_done(d0 + 1, 2000);
        chk("8n1_ticks", cap.size(), 160);
        chk("8n1_done", done_cnt - d0, 1);
        check_frame("8n1_bits", "0101001011", 0);

        // 7E2 0x41.
        cfg_len = 2'b10; cfg_par = 2'b01; cfg_stop2 = 1'b1;
        cap.delete();
        d0 = done_cnt;
        push(8'h41);
        wait_done(d0 + 1, 2000);
        chk("7e2_ticks", cap.size(), 176);
        check_frame("7e2_bits", "01000001011", 0);

        // 5O1 0xFF, tick every other clk.
        cfg_len = 2'b00; cfg_par = 2'b10; cfg_stop2 = 1'b0;
        tick_div = 2;
        cap.delete();
        d0 = done_cnt;
        push(8'hFF);
        wait_done(d0 + 1, 2000);
        chk("5o1_ticks", cap.size(), 128);
        check_frame("5o1_bits", "01111101", 0);
        tick_div = 1;

        // Back-to-back 0x11, 0x22 at 8N1.
        cfg_len = 2'b11; cfg_par = 2'b00; cfg_stop2 = 1'b0;
        cap.delete();
        d0 = done_cnt;
        r0 = rd_cnt;
        last_gap = 99;
        push(8'h11);
        push(8'h22);
        wait_done(d0 + 2, 4000);
        chk("b2b_pops", rd_cnt - r0, 2);
        chk("b2b_gap", (last_gap >= 0 && last_gap <= 1), 1);
        chk("b2b_ticks", cap.size(), 320);
        check_frame("b2b_bits0", "0100010001", 0);
        check_frame("b2b_bits1", "0010001001", 160);

        // Reset during data bit 3 of 0xA5 (bit 3 is 0).
        cap.delete();
        push(8'hA5);
        wait_cap(16 * 4 + 5, 2000);
        chk("pre_rst_txd", txd, 0);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_txd", txd, 1);
        chk("mid_rst_busy", busy, 0);
        step(2);
        reset_n = 1'b1;
        r0 = rd_cnt;
        step(40);
        chk("post_rst_pops", rd_cnt - r0, 0);
        chk("post_rst_busy", busy, 0);

        // Config changes, tx_en drop and tick gap mid-frame.
        cfg_len = 2'b11; cfg_par = 2'b00; cfg_stop2 = 1'b0;
        cap.delete();
        d0 = done_cnt;
        r0 = rd_cnt;
        push(8'h3C);
        push(8'h99);
        wait_cap(40, 2000);
        cfg_len = 2'b00; cfg_par = 2'b01; cfg_stop2 = 1'b1;
        tx_en = 1'b0;
        tick_on = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            chk("gap_txd", txd, 0);
            chk("gap_busy", busy, 1);
        end
        tick_on = 1'b1;
        wait_done(d0 + 1, 2000);
        chk("cfgchg_ticks", cap.size(), 160);
        check_frame("cfgchg_bits", "0001111001", 0);
        step(40);
        chk("txen_pops", rd_cnt - r0, 1);
        chk("txen_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
